// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte out on device clock falling edges and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES    = 12000,
    parameter int START_CYCLES      = 100,
    parameter int FIRST_CLK_TIMEOUT = 1500000,
    parameter int FRAME_TIMEOUT     = 200000,
    parameter int FILTER_LEN        = 8
) (
    input  logic       clk_100mhz,
    input  logic       rstn_i,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_stb,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_err_code,
    output logic       o_rx_inhibit
);

    localparam int TW  = 21;
    localparam int FCW = $clog2(FILTER_LEN + 1);

    localparam logic [TW-1:0]  INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0]  START_LAST = TW'(START_CYCLES - 1);
    localparam logic [TW-1:0]  FIRST_LAST = TW'(FIRST_CLK_TIMEOUT - 1);
    localparam logic [TW-1:0]  FRAME_LAST = TW'(FRAME_TIMEOUT - 1);
    localparam logic [FCW-1:0] FLT_LAST   = FCW'(FILTER_LEN - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NO_CLK  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_NO_ACK  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_WAIT_CLK,
        S_SHIFT,
        S_STOP,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    // ---------------- input conditioning ----------------
    logic           clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall;

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            clk_meta_q  <= i_ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= i_ps2_data;
            data_sync_q <= data_meta_q;
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (fcnt_q == FLT_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_q & ~filt_d;

    // ---------------- FSM ----------------
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [8:0]      sr_q, sr_d;
    logic            tx_bit_q, tx_bit_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;

    always_ff @(posedge clk_100mhz or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            sr_q     <= '0;
            tx_bit_q <= 1'b1;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            sr_q     <= sr_d;
            tx_bit_q <= tx_bit_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    logic       fin;
    logic [1:0] fin_code;

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        sr_d     = sr_q;
        tx_bit_d = tx_bit_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = err_q;
        fin      = 1'b0;
        fin_code = ERR_OK;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                // The done cycle still counts as busy, so a strobe there is dropped.
                if (i_tx_stb && !done_q) begin
                    state_d = S_INHIBIT;
                    sr_d    = {~^i_tx_data, i_tx_data};
                    err_d   = ERR_OK;
                end
            end
            S_INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end
            S_START: begin
                if (timer_q == START_LAST) begin
                    state_d = S_WAIT_CLK;
                    timer_d = '0;
                end
            end
            S_WAIT_CLK: begin
                if (fall) begin
                    state_d  = S_SHIFT;
                    timer_d  = '0;
                    tx_bit_d = sr_q[0];
                    sr_d     = {1'b0, sr_q[8:1]};
                    cnt_d    = 4'd1;
                end else if (timer_q == FIRST_LAST) begin
                    fin      = 1'b1;
                    fin_code = ERR_NO_CLK;
                end
            end
            S_SHIFT: begin
                if (timer_q == FRAME_LAST) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end else if (fall) begin
                    tx_bit_d = sr_q[0];
                    sr_d     = {1'b0, sr_q[8:1]};
                    cnt_d    = cnt_q + 1'b1;
                    // Ninth edge puts parity on the line; hold it until edge 10.
                    if (cnt_q == 4'd8) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (timer_q == FRAME_LAST) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end else if (fall) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (timer_q == FRAME_LAST) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end else if (fall) begin
                    if (data_sync_q) begin
                        fin      = 1'b1;
                        fin_code = ERR_NO_ACK;
                    end else begin
                        state_d = S_WAIT_IDLE;
                        timer_d = '0;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (filt_q && data_sync_q) begin
                    fin      = 1'b1;
                    fin_code = ERR_OK;
                end else if (timer_q == FRAME_LAST) begin
                    fin      = 1'b1;
                    fin_code = ERR_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d = S_IDLE;
            timer_d = '0;
            done_d  = 1'b1;
            err_d   = fin_code;
        end
    end

    // Pin enables decode straight from state so an async reset frees the bus at once.
    always_comb begin
        o_ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_START);
        o_ps2_data_oe = (state_q == S_START) || (state_q == S_WAIT_CLK) ||
                        (((state_q == S_SHIFT) || (state_q == S_STOP)) && !tx_bit_q);
        o_busy        = (state_q != S_IDLE) || done_q;
        o_rx_inhibit  = o_busy || (state_q == S_WAIT_IDLE);
        o_done        = done_q;
        o_err_code    = err_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host and the bench compares sampled bits, error codes and timing to constants.
module tb_ps2_host_tx;

    localparam int INH   = 20;
    localparam int STRT  = 5;
    localparam int FCT   = 300;
    localparam int FRAME = 2000;
    localparam int FILT  = 4;
    localparam int HALF  = 40;

    logic       clk = 1'b0;
    logic       rstn;
    logic       stb = 1'b0;
    logic [7:0] txd = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_w, ps2_data_w;
    logic       o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done, o_rx_inhibit;
    logic [1:0] o_err_code;

    int         n_chk = 0;
    int         n_err = 0;
    int         done_seen = 0;
    logic [1:0] last_err = 2'd0;
    logic       busy_all;

    assign ps2_clk_w  = dev_clk & ~o_ps2_clk_oe;
    assign ps2_data_w = dev_data & ~o_ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES   (INH),
        .START_CYCLES     (STRT),
        .FIRST_CLK_TIMEOUT(FCT),
        .FRAME_TIMEOUT    (FRAME),
        .FILTER_LEN       (FILT)
    ) dut (
        .clk_100mhz   (clk),
        .rstn_i       (rstn),
        .i_tx_data    (txd),
        .i_tx_stb     (stb),
        .i_ps2_clk    (ps2_clk_w),
        .i_ps2_data   (ps2_data_w),
        .o_ps2_clk_oe (o_ps2_clk_oe),
        .o_ps2_data_oe(o_ps2_data_oe),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err_code   (o_err_code),
        .o_rx_inhibit (o_rx_inhibit)
    );

    always @(negedge clk) begin
        if (o_done) begin
            done_seen = done_seen + 1;
            last_err  = o_err_code;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        @(posedge clk);
        #1;
        txd = d;
        stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        int t = 0;
        while (done_seen == base && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        ok = (done_seen == base + 1);
    endtask

    // Device side: wait for request-to-send, then clock n_edges falling edges,
    // sampling the host data line on each rising edge and driving the ack.
    task automatic dev_xfer(input int n_edges, input bit ack, input int rst_edge,
                            output logic [10:0] bits, output bit ok);
        int t = 0;
        bits = '0;
        ok   = 1'b0;
        @(negedge clk);
        while (!(ps2_clk_w && !ps2_data_w) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) return;
        ok = 1'b1;
        bits[0] = ps2_data_w;
        for (int e = 1; e <= n_edges; e++) begin
            wait_cycles(HALF);
            dev_clk = 1'b0;
            if (e == rst_edge) begin
                wait_cycles(HALF / 2);
                chk("pre_rst_doe", 32'(o_ps2_data_oe), 32'd1);
                rstn = 1'b0;
                #1;
                chk("rst_release", 32'({o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done}), 32'd0);
                dev_clk = 1'b1;
                wait_cycles(3);
                rstn = 1'b1;
                return;
            end
            wait_cycles(HALF);
            dev_clk = 1'b1;
            if (e <= 10) begin
                bits[e]  = ps2_data_w;
                busy_all = busy_all & o_busy;
            end
            if (e == 10 && ack) dev_data = 1'b0;
            if (e == 11) dev_data = 1'b1;
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input int n_edges, input bit ack,
                            input int rst_edge, input bit dup,
                            input logic [1:0] exp_err, input logic [10:0] exp_bits);
        int         base;
        logic [10:0] bits;
        bit         ok;
        base = done_seen;
        send(d);
        @(negedge clk);
        chk("accept", 32'({o_busy, o_ps2_clk_oe}), 32'd3);
        if (dup) begin
            wait_cycles(3);
            send(8'h55);
        end
        busy_all = 1'b1;
        dev_xfer(n_edges, ack, rst_edge, bits, ok);
        chk("dev_request", 32'(ok), 32'd1);
        if (rst_edge != 0) begin
            $display("xfer data=%02h reset at edge %0d", d, rst_edge);
            return;
        end
        if (n_edges == 11) chk("frame_bits", 32'(bits), 32'(exp_bits));
        chk("busy_thru", 32'(busy_all), 32'd1);
        wait_done(base, ok);
        chk("done_pulse", 32'(ok), 32'd1);
        chk("err_code", 32'(last_err), 32'(exp_err));
        $display("xfer data=%02h edges=%0d bits=%03h err=%0d", d, n_edges, bits, last_err);
    endtask

    initial begin
        int base;
        int n;
        int n2;
        int k;
        rstn = 1'b0;
        wait_cycles(3);
        chk("reset_outs", 32'({o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done, o_rx_inhibit, o_err_code}), 32'd0);
        rstn = 1'b1;
        wait_cycles(3);
        chk("idle_outs", 32'({o_ps2_clk_oe, o_ps2_data_oe, o_busy, o_done, o_rx_inhibit, o_err_code}), 32'd0);

        // {stop, parity, data, start}
        run_xfer(8'hED, 11, 1'b1, 0, 1'b0, 2'd0, 11'b1_1_11101101_0);
        run_xfer(8'hED, 11, 1'b1, 0, 1'b1, 2'd0, 11'b1_1_11101101_0);
        run_xfer(8'h01, 11, 1'b1, 0, 1'b0, 2'd0, 11'b1_0_00000001_0);
        // strobe lands in the cycle right after the previous o_done
        run_xfer(8'hFF, 11, 1'b1, 0, 1'b0, 2'd0, 11'b1_1_11111111_0);

        run_xfer(8'hEE, 11, 1'b0, 0, 1'b0, 2'd3, 11'b1_1_11101110_0);
        wait_cycles(10);
        chk("err_hold", 32'(o_err_code), 32'd3);
        chk("idle_after_err", 32'({o_ps2_clk_oe, o_ps2_data_oe, o_busy}), 32'd0);

        run_xfer(8'hF4, 5, 1'b1, 0, 1'b0, 2'd2, 11'd0);

        // device never clocks
        base = done_seen;
        send(8'hEE);
        n  = 0;
        n2 = 0;
        @(negedge clk);
        while (o_ps2_clk_oe && n < 1000) begin
            n++;
            if (o_ps2_data_oe) n2++;
            @(negedge clk);
        end
        chk("inhibit_len", 32'(n), 32'(INH + STRT));
        chk("start_len", 32'(n2), 32'(STRT));
        chk("wait_clk_doe", 32'(o_ps2_data_oe), 32'd1);
        k = 0;
        while (!o_done && k < 2000) begin
            k++;
            @(negedge clk);
        end
        chk("noclk_time", 32'(k), 32'(FCT));
        chk("noclk_err", 32'(o_err_code), 32'd1);
        @(negedge clk);
        chk("noclk_release", 32'({o_ps2_clk_oe, o_ps2_data_oe, o_busy}), 32'd0);
        chk("noclk_done_cnt", 32'(done_seen), 32'(base + 1));
        $display("xfer data=ee no device clock, timeout after %0d cycles", k);

        // reset during SHIFT, then a clean transfer
        base = done_seen;
        run_xfer(8'h01, 11, 1'b1, 4, 1'b0, 2'd0, 11'd0);
        wait_cycles(5);
        chk("rst_no_done", 32'(done_seen), 32'(base));
        chk("rst_idle", 32'({o_busy, o_ps2_clk_oe, o_ps2_data_oe}), 32'd0);
        run_xfer(8'hFF, 11, 1'b1, 0, 1'b0, 2'd0, 11'b1_1_11111111_0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
